// File: rtl/alu_uart_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_uart_ctrl_if
// Description : Byte-level bundle between the UART, the ALU and the
//               alu_uart_ctrl sequencer.
//               master : sequencer side (drives ALU operands and TX request)
//               slave  : UART/ALU side (drives RX/TX strobes and ALU result)
//   i_rx_done    UART byte-received strobe (rising edge is the event)
//   i_rx_data    received byte
//   i_tx_done    UART transmit-complete strobe (rising edge is the event)
//   i_alu_result combinational ALU output
//   o_op_a/o_op_b/o_opcode  registered ALU operands
//   o_tx_signal  one-cycle transmit-start pulse
//   o_tx_result  byte to transmit
//   o_busy       high while a result is being computed or transmitted
//   o_overrun    sticky: a byte arrived while busy
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_uart_ctrl_if #(
  parameter int SIZEDATA = 8,
  parameter int SIZEOP   = 6
);
  logic                i_rx_done;
  logic [SIZEDATA-1:0] i_rx_data;
  logic                i_tx_done;
  logic [SIZEDATA-1:0] i_alu_result;
  logic [SIZEDATA-1:0] o_op_a;
  logic [SIZEDATA-1:0] o_op_b;
  logic [SIZEOP-1:0]   o_opcode;
  logic                o_tx_signal;
  logic [SIZEDATA-1:0] o_tx_result;
  logic                o_busy;
  logic                o_overrun;

  modport master (
    input  i_rx_done, i_rx_data, i_tx_done, i_alu_result,
    output o_op_a, o_op_b, o_opcode, o_tx_signal, o_tx_result, o_busy, o_overrun
  );

  modport slave (
    output i_rx_done, i_rx_data, i_tx_done, i_alu_result,
    input  o_op_a, o_op_b, o_opcode, o_tx_signal, o_tx_result, o_busy, o_overrun
  );
endinterface
`default_nettype wire

// File: rtl/alu_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_uart_ctrl
// Description : Sequencer between UART and ALU. Collects operand A, operand B
//               and opcode bytes, presents them to the ALU, captures the
//               result one cycle later and requests its transmission.
//   i_clock     system clock
//   i_reset     asynchronous active-high reset
//   bus         alu_uart_ctrl_if.master (UART strobes/data, ALU operands,
//               TX request, busy and overrun flags)
//   o_timeout   (only with ALU_UART_CTRL_TIMEOUT_EN) one-cycle pulse when a
//               partial transaction is abandoned after TIMEOUT_CYCLES idle
//               clocks in WAIT_B/WAIT_OP
// Optional    : define ALU_UART_CTRL_TIMEOUT_EN to enable the inter-byte
//               timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_uart_ctrl #(
  parameter int SIZEDATA       = 8,
  parameter int SIZEOP         = 6,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic i_clock,
  input  logic i_reset,
  alu_uart_ctrl_if.master bus
`ifdef ALU_UART_CTRL_TIMEOUT_EN
  ,
  output logic o_timeout
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_CALC    = 3'd3,
    S_SEND    = 3'd4,
    S_WAIT_TX = 3'd5
  } state_t;

  state_t              state_q;
  logic                rx_done_q;
  logic                tx_done_q;
  logic [SIZEDATA-1:0] op_a_q;
  logic [SIZEDATA-1:0] op_b_q;
  logic [SIZEOP-1:0]   opcode_q;
  logic [SIZEDATA-1:0] tx_result_q;
  logic                tx_signal_q;
  logic                busy_q;
  logic                overrun_q;
  logic                rx_evt;
  logic                tx_evt;

  assign rx_evt = bus.i_rx_done & ~rx_done_q;
  assign tx_evt = bus.i_tx_done & ~tx_done_q;

`ifdef ALU_UART_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
  logic             expire;
  // Fires on the last idle clock so the return to IDLE lands exactly
  // TIMEOUT_CYCLES clocks after the previous byte was accepted.
  assign expire    = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign o_timeout = timeout_q;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      rx_done_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      opcode_q    <= '0;
      tx_result_q <= '0;
      tx_signal_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef ALU_UART_CTRL_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      rx_done_q   <= bus.i_rx_done;
      tx_done_q   <= bus.i_tx_done;
      tx_signal_q <= 1'b0;
`ifdef ALU_UART_CTRL_TIMEOUT_EN
      timeout_q   <= 1'b0;
      // Counts only while a partial transaction is pending; any accepted
      // byte or any exit from the collecting states restarts it.
      if ((state_q == S_WAIT_B || state_q == S_WAIT_OP) && !rx_evt && !expire)
        cnt_q <= cnt_q + 1'b1;
      else
        cnt_q <= '0;
`endif

      // busy_q is high exactly in CALC/SEND/WAIT_TX, so it doubles as the
      // "byte arrived while busy" qualifier.
      if (rx_evt && busy_q)
        overrun_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (rx_evt) begin
            op_a_q  <= bus.i_rx_data;
            state_q <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (rx_evt) begin
            op_b_q  <= bus.i_rx_data;
            state_q <= S_WAIT_OP;
          end
`ifdef ALU_UART_CTRL_TIMEOUT_EN
          else if (expire) begin
            state_q   <= S_IDLE;
            timeout_q <= 1'b1;
          end
`endif
        end
        S_WAIT_OP: begin
          if (rx_evt) begin
            opcode_q <= bus.i_rx_data[SIZEOP-1:0];
            busy_q   <= 1'b1;
            state_q  <= S_CALC;
          end
`ifdef ALU_UART_CTRL_TIMEOUT_EN
          else if (expire) begin
            state_q   <= S_IDLE;
            timeout_q <= 1'b1;
          end
`endif
        end
        S_CALC: begin
          // Operands have been stable at the ALU for a full cycle here.
          tx_result_q <= bus.i_alu_result;
          tx_signal_q <= 1'b1;
          state_q     <= S_SEND;
        end
        S_SEND: begin
          state_q <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (tx_evt) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_op_a      = op_a_q;
  assign bus.o_op_b      = op_b_q;
  assign bus.o_opcode    = opcode_q;
  assign bus.o_tx_signal = tx_signal_q;
  assign bus.o_tx_result = tx_result_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_overrun   = overrun_q;

endmodule
`default_nettype wire

// File: doc/alu_uart_ctrl.md
Name: alu_uart_ctrl

Overview:
- Sequencing stage between the UART receiver/transmitter and the ALU inside TOP.
- Collects three received bytes in order: operand A, operand B, opcode. Drives the ALU with them, captures the result, and hands the result byte to the UART transmitter.
- Byte-level flow control only; bit timing and baud generation stay in UART.

Parameters:
- SIZEDATA, 8, width of operands, result and UART data bytes.
- SIZEOP, 6, opcode width; opcode is taken from the low SIZEOP bits of the third byte.
- TIMEOUT_CYCLES, 2000000, idle-clock limit between bytes of one transaction (used only with the optional feature).

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_rx_done  in  1  UART byte-received strobe; the rising edge is the event.
- i_rx_data  in  SIZEDATA  received byte; valid when i_rx_done rises.
- i_tx_done  in  1  UART transmit-complete strobe; the rising edge is the event.
- i_alu_result  in  SIZEDATA  combinational ALU output.
- o_op_a  out  SIZEDATA  registered operand A to ALU.
- o_op_b  out  SIZEDATA  registered operand B to ALU.
- o_opcode  out  SIZEOP  registered opcode to ALU.
- o_tx_signal  out  1  transmit-start pulse to UART.
- o_tx_result  out  SIZEDATA  byte to transmit; held stable from SEND until return to IDLE.
- o_busy  out  1  high in CALC, SEND and WAIT_TX.
- o_overrun  out  1  sticky flag: a byte arrived while busy.

Behaviour:
- Reset (async, asserts immediately, releases on the next clock edge):
  - All outputs 0.
  - State IDLE.
  - Edge-detect registers cleared.
  - o_overrun cleared.
- Event detection: rx_evt = i_rx_done & ~rx_done_q, and tx_evt likewise. Both are one clock wide; the _q registers are updated every clock.
- States and transitions:
  - IDLE: on rx_evt, latch o_op_a <= i_rx_data, go to WAIT_B.
  - WAIT_B: on rx_evt, latch o_op_b, go to WAIT_OP.
  - WAIT_OP: on rx_evt, latch o_opcode <= i_rx_data[SIZEOP-1:0], go to CALC.
  - CALC: exactly one cycle, lets the ALU settle. Latch o_tx_result <= i_alu_result, go to SEND.
  - SEND: o_tx_signal = 1 for exactly one cycle, go to WAIT_TX.
  - WAIT_TX: on tx_evt, go to IDLE.
- Latency: opcode rx_evt at cycle N gives CALC at N+1, o_tx_result valid at N+2, and o_tx_signal high at cycle N+2.
- Register holding: operand and opcode registers hold their values until overwritten by the next transaction; they are not cleared at the end of a transaction.
- rx_evt while in CALC/SEND/WAIT_TX: byte discarded, o_overrun <= 1 (sticky until reset), no state change.
- tx_evt in any state other than WAIT_TX: ignored.
- rx_evt and tx_evt in the same cycle in WAIT_TX: go to IDLE, the byte is discarded and o_overrun is set.
- Opcode byte upper bits (7:SIZEOP): ignored. Unknown opcodes are passed through; the ALU defines the result.
- Reset mid-transaction: partial operands are discarded and state returns to IDLE. A UART frame in flight is not this block's concern.
- No arithmetic in this block; all widths pass straight through.

Optional Feature:
- Macro ALU_UART_CTRL_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in WAIT_B and WAIT_OP.
  - The counter clears on every rx_evt and on entry to IDLE.
  - On reaching TIMEOUT_CYCLES, state returns to IDLE and the partial transaction is dropped (registers keep their stale values).
  - Output o_timeout (1 bit, extra port present only under the macro) pulses high for one cycle; reset value 0.
- When undefined: no counter, no o_timeout port, and WAIT_B/WAIT_OP wait indefinitely.

Test Plan:
- Send 0x05, 0x03, 0x20 (ADD) with the ALU stub returning a+b -> o_op_a=0x05, o_op_b=0x03, o_opcode=0x20; o_tx_result=0x08; o_tx_signal pulses once, 2 cycles after the opcode rx edge; o_busy high until tx_done.
- Send 0xF0, 0x03, 0x03 (SRA) -> o_opcode=0x03, o_tx_result=0xFE; a second transaction 0x80, 0x03, 0x02 (SRL) -> 0x10; state IDLE between the two.
- During WAIT_TX inject an rx_done pulse with 0xAA -> state unchanged, o_op_a not overwritten, o_overrun=1 and stays 1 through the next full transaction.
- Assert i_reset after two bytes received -> all outputs 0 immediately; a subsequent 3-byte sequence 0x01, 0x01, 0x22 completes normally.
- Hold i_rx_done high for 5 cycles -> counted as one byte only; stray tx_done in IDLE -> no effect.
- With ALU_UART_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=100: send one byte, then idle for 100 cycles -> o_timeout one-cycle pulse, state IDLE; the next 3 bytes form a fresh transaction.
